// File: rtl/multicycle_arithmetic_logic_unit.sv
// Registered ALU: single-cycle logic/arithmetic/compare ops, plus iterative
// shift-add multiply and restoring divide into HI/LO behind a valid/ready handshake.
module multicycle_arithmetic_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_input,
    output logic             ready_output,
    input  logic [3:0]       control_input,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             result_valid_output,
    output logic [WIDTH-1:0] result_output,
    output logic             zero_output,
    output logic             overflow_output,
    output logic             divide_by_zero_output,
    output logic [WIDTH-1:0] hi_output,
    output logic [WIDTH-1:0] lo_output
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_XOR   = 4'b1101;

    localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULTIPLY, DIVIDE, FINISH} state_e;
    typedef enum logic [1:0] {KIND_MUL, KIND_DIV, KIND_DBZ} kind_e;

    state_e state, state_next;
    kind_e  kind;

    logic [WIDTH-1:0] counter;
    logic [WIDTH:0]   acc_hi;      // partial product high half / running remainder
    logic [WIDTH-1:0] acc_lo;      // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0] operand_mag; // multiplicand or divisor magnitude
    logic             negate_lo;
    logic             negate_hi;

    logic accept, is_mult, is_div, is_signed_op, divisor_zero;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign ready_output = (state == IDLE);
    assign accept       = valid_input && ready_output;

    always_comb begin
        is_mult      = (control_input == OP_MULT) || (control_input == OP_MULTU);
        is_div       = (control_input == OP_DIV)  || (control_input == OP_DIVU);
        is_signed_op = (control_input == OP_MULT) || (control_input == OP_DIV);
        divisor_zero = (operand_b == '0);
        mag_a        = (is_signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        mag_b        = (is_signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    end

    // Single-cycle datapath.
    logic [WIDTH-1:0] alu_sum, alu_diff, alu_result;
    logic             alu_overflow, alu_known;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_known    = 1'b1;
        alu_sum      = operand_a + operand_b;
        alu_diff     = operand_a - operand_b;
        case (control_input)
            OP_AND:  alu_result = operand_a & operand_b;
            OP_OR:   alu_result = operand_a | operand_b;
            OP_NOR:  alu_result = ~(operand_a | operand_b);
            OP_XOR:  alu_result = operand_a ^ operand_b;
            OP_ADD: begin
                alu_result   = alu_sum;
                alu_overflow = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                               (alu_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result   = alu_diff;
                alu_overflow = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                               (alu_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            default: alu_known  = 1'b0;
        endcase
    end

    // Iterative step logic.
    logic [WIDTH:0] mul_sum, div_shift, div_diff;
    logic           div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + {1'b0, (acc_lo[0] ? operand_mag : '0)};
        div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, operand_mag});
        div_diff  = div_shift - {1'b0, operand_mag};
    end

    // Sign correction and final HI/LO selection.
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        product = {acc_hi[WIDTH-1:0], acc_lo};
        if (negate_lo) product = -product;
        fin_hi = product[2*WIDTH-1:WIDTH];
        fin_lo = product[WIDTH-1:0];
        case (kind)
            KIND_DIV: begin
                fin_lo = negate_lo ? -acc_lo : acc_lo;
                fin_hi = negate_hi ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
            end
            KIND_DBZ: begin
                fin_lo = '1;
                fin_hi = acc_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mult)     state_next = MULTIPLY;
                else if (accept && is_div) state_next = divisor_zero ? FINISH : DIVIDE;
            end
            MULTIPLY: if (counter == LAST_STEP) state_next = FINISH;
            DIVIDE:   if (counter == LAST_STEP) state_next = FINISH;
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kind                  <= KIND_MUL;
            counter               <= '0;
            acc_hi                <= '0;
            acc_lo                <= '0;
            operand_mag           <= '0;
            negate_lo             <= 1'b0;
            negate_hi             <= 1'b0;
            result_valid_output   <= 1'b0;
            result_output         <= '0;
            zero_output           <= 1'b0;
            overflow_output       <= 1'b0;
            divide_by_zero_output <= 1'b0;
            hi_output             <= '0;
            lo_output             <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            result_valid_output   <= 1'b0;
            divide_by_zero_output <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && is_mult) begin
                        kind        <= KIND_MUL;
                        acc_hi      <= '0;
                        acc_lo      <= mag_b;
                        operand_mag <= mag_a;
                        negate_lo   <= is_signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        counter     <= '0;
                    end else if (accept && is_div) begin
                        counter     <= '0;
                        acc_hi      <= '0;
                        operand_mag <= mag_b;
                        if (divisor_zero) begin
                            kind   <= KIND_DBZ;
                            acc_lo <= operand_a;
                        end else begin
                            kind   <= KIND_DIV;
                            acc_lo <= mag_a;
                        end
                        negate_lo <= is_signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                        negate_hi <= is_signed_op && operand_a[WIDTH-1];
                    end else if (accept) begin
                        result_output       <= alu_result;
                        zero_output         <= alu_known && (alu_result == '0);
                        overflow_output     <= alu_overflow;
                        result_valid_output <= 1'b1;
                    end
                end
                MULTIPLY: begin
                    acc_hi  <= {1'b0, mul_sum[WIDTH:1]};
                    acc_lo  <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    counter <= counter + WIDTH'(1);
                end
                DIVIDE: begin
                    acc_hi  <= div_ge ? div_diff : div_shift;
                    acc_lo  <= {acc_lo[WIDTH-2:0], div_ge};
                    counter <= counter + WIDTH'(1);
                end
                FINISH: begin
                    hi_output             <= fin_hi;
                    lo_output             <= fin_lo;
                    result_output         <= fin_lo;
                    zero_output           <= (fin_lo == '0);
                    overflow_output       <= 1'b0;
                    result_valid_output   <= 1'b1;
                    divide_by_zero_output <= (kind == KIND_DBZ);
                end
                default: ;
            endcase
        end
    end

endmodule
